// File: rtl/pm_job_sequencer_if.sv
// pm_job_sequencer_if: operand, multiplier and result ports of the job sequencer
interface pm_job_sequencer_if #(
  parameter int SIZE = 32,
  parameter int DEPTH = 4
);
  logic in_valid, in_ready;
  logic [SIZE-1:0] in_mc, in_mp, mul_mc, mul_mp;
  logic mul_start, mul_done;
  logic [2*SIZE-1:0] mul_p, out_p;
  logic out_valid, out_ready, out_err, busy;
  logic [$clog2(DEPTH):0] level;
  modport slave (
    input in_valid, in_mc, in_mp, mul_p, mul_done, out_ready,
    output in_ready, mul_start, mul_mc, mul_mp, out_valid, out_p, out_err, busy, level
  );
  modport master (
    output in_valid, in_mc, in_mp, mul_p, mul_done, out_ready,
    input in_ready, mul_start, mul_mc, mul_mp, out_valid, out_p, out_err, busy, level
  );
endinterface

// File: rtl/pm_job_sequencer.sv
// pm_job_sequencer: FIFO-buffered job issue and in-order result return around the pm32 multiplier
module pm_job_sequencer #(
  parameter int SIZE = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  pm_job_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, next;
  logic [2*SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] fill;
  logic [CW-1:0] cnt;
  logic done_q, push, pop, done_edge, expired;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = state == IDLE && fill != '0;
  assign done_edge = bus.mul_done && !done_q;
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = pop ? ISSUE : IDLE;
      ISSUE: next = WAIT;
      WAIT: next = done_edge || expired ? HOLD : WAIT;
      HOLD: next = bus.out_ready ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.mul_start = state == ISSUE;
    bus.out_valid = state == HOLD;
    bus.in_ready = fill != (AW+1)'(DEPTH);
    bus.busy = state != IDLE || fill != '0;
    bus.level = fill;
  end
  always_ff @(posedge clk)
    if (push) mem[wr] <= {bus.in_mc, bus.in_mp};
  // a done level left high by the previous job never completes the current one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      fill <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      bus.mul_mc <= '0;
      bus.mul_mp <= '0;
      bus.out_p <= '0;
      bus.out_err <= 1'b0;
    end else begin
      done_q <= bus.mul_done;
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr <= wr + 1'b1;
      if (pop) begin
        rd <= rd + 1'b1;
        {bus.mul_mc, bus.mul_mp} <= mem[rd];
      end
      cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      if (state == WAIT && (done_edge || expired)) begin
        bus.out_p <= done_edge ? bus.mul_p : '0;
        bus.out_err <= !done_edge;
      end
    end
endmodule

// File: tb/tb_pm_job_sequencer.sv
// tb_pm_job_sequencer: randomized scoreboard bench with a behavioural multiplier model
module tb_pm_job_sequencer;
  localparam int SIZE = 32;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 40;
  typedef struct {int lat; bit hang; bit stale;} job_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_start = 0, n_seen = 0;
  int push_cyc = 0, start_cyc = 0, exp_valid_cyc = 0;
  bit rand_rdy = 1'b0, rdy_force = 1'b1, prev_v = 1'b0, prev_start = 1'b0, bg_done;
  job_t job_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] cur = '0;
  pm_job_sequencer_if #(.SIZE(SIZE), .DEPTH(DEPTH)) b ();
  pm_job_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) #1 b.out_ready = rand_rdy ? $urandom_range(0, 3) != 0 : rdy_force;
  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as required", nm);
  endtask
  task automatic check_reset_vals(input string nm);
    check({nm, "_in_ready"}, b.in_ready, 1);
    check({nm, "_mul_start"}, b.mul_start, 0);
    check({nm, "_mul_mc"}, b.mul_mc, 0);
    check({nm, "_mul_mp"}, b.mul_mp, 0);
    check({nm, "_out_valid"}, b.out_valid, 0);
    check({nm, "_out_p"}, b.out_p, 0);
    check({nm, "_out_err"}, b.out_err, 0);
    check({nm, "_busy"}, b.busy, 0);
    check({nm, "_level"}, b.level, 0);
  endtask
  // multiplier: product appears lat cycles after start; done level held until the next start
  initial begin
    job_t j;
    logic [31:0] mc, mp;
    b.mul_done = 1'b0;
    b.mul_p = '0;
    forever begin
      @(negedge clk);
      if (rst && b.mul_start) begin
        n_start++;
        if (job_q.size() == 0) fail("spurious_start");
        else begin
          j = job_q.pop_front();
          start_cyc = cyc;
          mc = b.mul_mc;
          mp = b.mul_mp;
          if (j.hang) exp_valid_cyc = cyc + TIMEOUT + 1;
          if (j.stale) repeat (3) @(negedge clk);
          b.mul_done = 1'b0;
          b.mul_p = {$urandom, $urandom};
          if (!j.hang) begin
            repeat (j.lat) @(negedge clk);
            b.mul_p = 64'(mc) * 64'(mp);
            b.mul_done = 1'b1;
            exp_valid_cyc = cyc + 1;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst && b.mul_start && prev_start) fail("start_width");
    prev_start = rst && b.mul_start;
  end
  always @(negedge clk) begin
    if (rst && b.out_valid) begin
      if (!prev_v) begin
        n_seen++;
        check("valid_cycle", cyc, exp_valid_cyc);
        if (exp_q.size() == 0) begin
          fail("unexpected_result");
          cur = 'x;
        end else begin
          cur = exp_q.pop_front();
          check("result", {b.out_err, b.out_p}, cur);
        end
      end else if (!$isunknown(cur)) check("hold_stable", {b.out_err, b.out_p}, cur);
    end
    prev_v = rst && b.out_valid;
  end
  task automatic push(input logic [31:0] mc, input logic [31:0] mp, input int lat, input bit hang, input bit stale);
    int t;
    job_t j;
    t = 0;
    b.in_valid = 1'b1;
    b.in_mc = mc;
    b.in_mp = mp;
    @(negedge clk);
    while (!b.in_ready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (b.in_ready) begin
      j.lat = lat;
      j.hang = hang;
      j.stale = stale;
      job_q.push_back(j);
      exp_q.push_back(hang ? {1'b1, 64'h0} : {1'b0, 64'(mc) * 64'(mp)});
      push_cyc = cyc;
    end else fail("push_stuck");
    @(posedge clk);
    #1 b.in_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || b.busy) && t < 3000) begin
      t++;
      @(negedge clk);
    end
    check({nm, "_busy"}, b.busy, 0);
    check({nm, "_pending"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : $urandom;
  endfunction
  initial begin
    int s0, t;
    logic [31:0] mc, mp;
    rst = 1'b0;
    b.in_valid = 1'b0;
    b.in_mc = '0;
    b.in_mp = '0;
    repeat (3) @(posedge clk);
    #4 check_reset_vals("por");
    @(posedge clk);
    #1 rst = 1'b1;
    s0 = n_start;
    push(56, 101, 34, 0, 0);
    drain("single");
    check("single_starts", n_start - s0, 1);
    check("push_to_start", start_cyc, push_cyc + 2);
    rdy_force = 1'b0;
    s0 = n_start;
    push(3, 7, 8, 0, 0);
    push(0, 9, 5, 0, 0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 12, 0, 0);
    push(1, 1, 3, 0, 0);
    push(12, 12, 20, 0, 0);
    @(negedge clk);
    check("full_level", b.level, DEPTH);
    check("full_ready", b.in_ready, 0);
    bg_done = 1'b0;
    fork
      begin
        push(9, 9, 4, 0, 0);
        bg_done = 1'b1;
      end
    join_none
    t = 0;
    while (!b.out_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("bp_first_valid", b.out_valid, 1);
    s0 = n_start;
    repeat (50) @(negedge clk);
    check("bp_no_start", n_start - s0, 0);
    check("bp_level", b.level, DEPTH);
    check("bp_valid", b.out_valid, 1);
    rdy_force = 1'b1;
    t = 0;
    while (!bg_done && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!bg_done) fail("fifth_push");
    @(posedge clk);
    #1 drain("burst");
    push(6, 7, 5, 0, 0);
    push(11, 13, 5, 0, 1);
    drain("stale");
    push(32'h1234, 32'h5678, 1, 1, 0);
    push(77, 88, 2, 0, 0);
    drain("timeout");
    s0 = n_start;
    push(56, 101, 34, 0, 0);
    push(2, 3, 5, 0, 0);
    push(4, 5, 5, 0, 0);
    t = 0;
    while (n_start == s0 && t < 100) begin
      t++;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    job_q.delete();
    s0 = n_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(negedge clk);
    check("discarded_results", n_seen - s0, 0);
    @(posedge clk);
    #1 push(56, 101, 10, 0, 0);
    drain("post_rst");
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mc = pick();
      mp = pick();
      push(mc, mp, $urandom_range(1, 34), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
